// File: rtl/inst_seq.sv
// inst_seq: program-word sequencer issuing instructions to a CPU with ack timeout and abort
module inst_seq #(
  parameter int DEPTH = 16,
  parameter int ACK_TMO = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int TW = $clog2(ACK_TMO + 1)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          sys_ld_en,
  input  logic [AW-1:0] sys_ld_addr,
  input  logic [31:0]   sys_ld_data,
  input  logic [AW:0]   sys_prog_len,
  input  logic          sys_run,
  input  logic          sys_abort,
  input  logic          sys_inst_st,
  output logic [31:0]   sys_inst_cmd,
  output logic          sys_inst_up,
  output logic          sys_busy,
  output logic          sys_done,
  output logic          sys_err,
  output logic [AW-1:0] sys_pc
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, ISSUE = 3'd2, WAIT_ACK = 3'd3, WAIT_RDY = 3'd4, DONE = 3'd5;
  logic [2:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   inst;
  logic [AW:0]   len_q;
  logic [TW-1:0] cnt;
  assign sys_busy = (state == FETCH) || (state == ISSUE) || (state == WAIT_ACK) || (state == WAIT_RDY);
  assign sys_done = state == DONE;
  always_ff @(posedge sys_clk)
    if (!sys_rst && sys_ld_en && state == IDLE) mem[sys_ld_addr] <= sys_ld_data;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      sys_inst_cmd <= '0;
      sys_inst_up  <= 1'b0;
      sys_err      <= 1'b0;
      sys_pc       <= '0;
      cnt          <= '0;
    end else begin
      sys_inst_up <= 1'b0;
      if (state != IDLE && sys_abort) state <= IDLE;
      else
        case (state)
          IDLE: if (sys_run) begin
            len_q <= sys_prog_len;
            if (sys_prog_len == '0) state <= DONE;
            else begin
              sys_pc  <= '0;
              sys_err <= 1'b0;
              state   <= FETCH;
            end
          end
          FETCH: begin
            inst  <= mem[sys_pc];
            state <= ISSUE;
          end
          ISSUE: if (inst[31:28] == 4'd0) state <= DONE;
          else if (sys_inst_st) begin
            sys_inst_cmd <= inst;
            sys_inst_up  <= 1'b1;
            cnt          <= '0;
            state        <= WAIT_ACK;
          end
          WAIT_ACK: if (!sys_inst_st) state <= WAIT_RDY;
          else if (cnt == TW'(ACK_TMO - 1)) begin
            sys_err <= 1'b1;
            state   <= IDLE;
          end else cnt <= cnt + 1'b1;
          WAIT_RDY: if (sys_inst_st) begin
            if ({1'b0, sys_pc} + 1'b1 == len_q) state <= DONE;
            else begin
              sys_pc <= sys_pc + 1'b1;
              state  <= FETCH;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
    end
  end
endmodule
